// File: rtl/demux8_tdm_rx.sv
//------------------------------------------------------------------------------
// Module      : demux8_tdm_rx
// Description : 1-bit TDM serial stream to 8-lane parallel word, sof-aligned,
//               with idle timeout and premature-restart error reporting.
//               Optional even-parity slot: define DEMUX8_PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux8_tdm_rx #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sof,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [2:0] slot,
    output logic       busy,
    output logic       frame_err
);

    localparam int c_GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

`ifdef DEMUX8_PARITY_CHECK_EN
    localparam int c_SLOT_W = 4;
`else
    localparam int c_SLOT_W = 3;
`endif
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(7);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_COLLECT = 1'b1;

    logic [0:0]          r_state;
    logic [c_SLOT_W-1:0] r_slot;
    logic [7:0]          r_shift;
    logic [c_GAP_W-1:0]  r_gap;
    logic [7:0]          r_dout;
    logic                r_dout_valid;
    logic                r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_slot       <= '0;
            r_shift      <= '0;
            r_gap        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (din_valid && sof) begin
                // A sof while collecting abandons the partial frame.
                r_frame_err <= (r_state == c_COLLECT);
                r_state     <= c_COLLECT;
                r_shift     <= {7'b0, din};
                r_slot      <= c_SLOT_ONE;
                r_gap       <= '0;
            end else if (r_state == c_COLLECT) begin
                if (din_valid) begin
                    r_gap <= '0;
`ifdef DEMUX8_PARITY_CHECK_EN
                    if (r_slot[3]) begin
                        if ((^r_shift) ^ din) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_dout       <= r_shift;
                            r_dout_valid <= 1'b1;
                        end
                        r_state <= c_IDLE;
                        r_slot  <= '0;
                        r_shift <= '0;
                    end else begin
                        r_shift[r_slot[2:0]] <= din;
                        r_slot               <= r_slot + c_SLOT_ONE;
                    end
`else
                    if (r_slot == c_SLOT_LAST) begin
                        r_dout       <= {din, r_shift[6:0]};
                        r_dout_valid <= 1'b1;
                        r_state      <= c_IDLE;
                        r_slot       <= '0;
                        r_shift      <= '0;
                    end else begin
                        r_shift[r_slot[2:0]] <= din;
                        r_slot               <= r_slot + c_SLOT_ONE;
                    end
`endif
                end else if (r_gap == c_GAP_LAST) begin
                    r_frame_err <= 1'b1;
                    r_state     <= c_IDLE;
                    r_slot      <= '0;
                    r_shift     <= '0;
                    r_gap       <= '0;
                end else begin
                    r_gap <= r_gap + c_GAP_ONE;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == c_COLLECT);
`ifdef DEMUX8_PARITY_CHECK_EN
    // The parity slot is not a lane, so the port reads 0 while it is pending.
    assign slot = r_slot[3] ? 3'd0 : r_slot[2:0];
`else
    assign slot = r_slot;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux8_tdm_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_demux8_tdm_rx
// Description : Scoreboard bench for demux8_tdm_rx against a frame-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux8_tdm_rx;

    localparam int TIMEOUT = 15;
`ifdef DEMUX8_PARITY_CHECK_EN
    localparam int c_FRAME = 9;
`else
    localparam int c_FRAME = 8;
`endif

    typedef struct {
        logic [7:0] dout;
        logic [2:0] slot;
        logic       busy;
        logic       dv;
        logic       fe;
    } st_t;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] slot;
    logic       busy;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    st_t st_q[$];
    ev_t ev_q[$];

    bit         m_in   = 1'b0;
    bit         m_bits[$];
    int         m_gap  = 0;
    logic [7:0] m_dout = 8'h00;

    demux8_tdm_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Frame-level reference: a frame is a list of received bits.
    task automatic model(input bit r, input bit v, input bit s, input bit d);
        st_t st;
        ev_t ev;
        bit  dv = 1'b0;
        bit  fe = 1'b0;
        bit  p  = 1'b0;
        if (r) begin
            m_in = 1'b0;
            m_bits.delete();
            m_gap  = 0;
            m_dout = 8'h00;
        end else if (v && s) begin
            fe = m_in;
            m_bits.delete();
            m_bits.push_back(d);
            m_in  = 1'b1;
            m_gap = 0;
        end else if (v && m_in) begin
            m_bits.push_back(d);
            m_gap = 0;
            if (m_bits.size() == c_FRAME) begin
                foreach (m_bits[i]) p ^= m_bits[i];
                if (c_FRAME == 9 && p) begin
                    fe = 1'b1;
                end else begin
                    for (int k = 0; k < 8; k++) m_dout[k] = m_bits[k];
                    dv = 1'b1;
                end
                m_in = 1'b0;
                m_bits.delete();
            end
        end else if (!v && m_in) begin
            m_gap++;
            if (m_gap >= TIMEOUT) begin
                fe   = 1'b1;
                m_in = 1'b0;
                m_bits.delete();
            end
        end
        st.dout = m_dout;
        st.slot = (m_in && m_bits.size() < 8) ? 3'(m_bits.size()) : 3'd0;
        st.busy = m_in;
        st.dv   = dv;
        st.fe   = fe;
        st_q.push_back(st);
        if (dv) begin
            ev.is_err = 1'b0;
            ev.data   = m_dout;
            ev_q.push_back(ev);
        end
        if (fe) begin
            ev.is_err = 1'b1;
            ev.data   = 8'h00;
            ev_q.push_back(ev);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit s, input bit d);
        @(negedge clk);
        rst = r; din_valid = v; sof = s; din = d;
        model(r, v, s, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Sends the first n slots of a frame; a gap of gap_len idles follows slot gap_at.
    task automatic send(input logic [7:0] w, input int n, input int gap_at,
                        input int gap_len, input bit bad_par);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1, k == 0, (k < 8) ? w[k] : ((^w) ^ bad_par));
            if (k == gap_at) idle(gap_len);
        end
    endtask

    initial begin : monitor
        st_t e;
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("dout", 32'(dout), 32'(e.dout));
                chk("slot", 32'(slot), 32'(e.slot));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("dout_valid", 32'(dout_valid), 32'(e.dv));
                chk("frame_err", 32'(frame_err), 32'(e.fe));
            end
            if (dout_valid === 1'b1 || frame_err === 1'b1) begin
                if (ev_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event at %0t: dv=%0b fe=%0b, none expected",
                             $time, dout_valid, frame_err);
                end else begin
                    ev = ev_q.pop_front();
                    if (ev.is_err) begin
                        chk("event_err", 32'(frame_err), 32'd1);
                    end else begin
                        chk("event_valid", 32'(dout_valid), 32'd1);
                        chk("event_dout", 32'(dout), 32'(ev.data));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        send(8'h4D, c_FRAME, -1, 0, 1'b0);
        idle(3);
        send(8'hFF, c_FRAME, -1, 0, 1'b0);
        send(8'h00, c_FRAME, -1, 0, 1'b0);
        idle(2);
        send(8'hA5, c_FRAME, 3, TIMEOUT - 1, 1'b0);
        idle(2);
        send(8'hA5, c_FRAME, 3, TIMEOUT, 1'b0);
        idle(2);
        send(8'h81, 5, -1, 0, 1'b0);
        send(8'h3C, c_FRAME, -1, 0, 1'b0);
        idle(1);
        send(8'h96, 4, -1, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        idle(2);
        send(8'h4D, c_FRAME, -1, 0, 1'b1);
        idle(2);
        for (int i = 0; i < 30; i++) begin
            send(8'($urandom), c_FRAME, $urandom_range(0, c_FRAME - 1),
                 $urandom_range(0, TIMEOUT), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) idle($urandom_range(10, 20));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
        end
        idle(4);
        @(posedge clk);
        #2;
        chk("events_drained", 32'(ev_q.size()), 32'd0);
        chk("states_drained", 32'(st_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux8_tdm_rx.md
Name: demux8_tdm_rx

Overview:
- Receive-side counterpart of the 8:1 lane mux.
- Takes a 1-bit time-division-multiplexed serial stream (slot 0 first, slot 7 last) and redistributes each slot's bit onto its own lane of an 8-bit parallel output word.
- Frame alignment comes from a start-of-frame marker.
- Completion is signalled by a one-cycle valid pulse. Malformed or stalled frames are signalled by an error pulse.

Parameters:
- TIMEOUT, 15: maximum consecutive idle cycles (din_valid low) tolerated mid-frame before abort. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  1  serial slot bit, sampled when din_valid=1
- din_valid  input  1  qualifies din and sof
- sof  input  1  start of frame; marks the current din as slot 0; ignored when din_valid=0
- dout  output  8  last completed frame; dout[k] = bit received in slot k
- dout_valid  output  1  one-cycle pulse when dout is updated
- slot  output  3  index of the next slot expected; 0 in IDLE
- busy  output  1  high while in COLLECT
- frame_err  output  1  one-cycle error pulse

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge): state=IDLE; dout=8'h00; dout_valid=0; slot=0; busy=0; frame_err=0; shift/capture register=0; gap counter=0. Reset takes priority over every other event, including mid-frame; a partial frame is discarded with no error pulse.
- States: IDLE, COLLECT.
- IDLE:
  - din_valid=1 and sof=1: capture din as bit 0; slot<=1; enter COLLECT.
  - din_valid=1 and sof=0: ignored; no error.
- COLLECT, din_valid=1 and sof=0:
  - Capture din at lane [slot]; slot<=slot+1; gap counter<=0.
  - When slot==7 (8th bit accepted):
    - dout<=captured word including this bit.
    - dout_valid<=1 for exactly one cycle.
    - Go to IDLE; slot<=0.
  - Latency: dout and dout_valid are visible in the cycle after the 8th bit is sampled.
- COLLECT, din_valid=1 and sof=1 (premature restart):
  - frame_err<=1 for one cycle.
  - Partial frame discarded; dout unchanged.
  - Current din captured as bit 0 of a new frame; slot<=1; stay in COLLECT.
- COLLECT, din_valid=0:
  - Gap counter increments.
  - On the cycle the counter reaches TIMEOUT: frame_err<=1; go to IDLE; slot<=0; capture register cleared; dout unchanged.
- Back-to-back frames: sof with din_valid in the cycle immediately after the 8th bit is accepted and starts a new frame with no bubble. dout_valid of the old frame and bit 0 of the new frame coincide legally.
- dout holds its value between completed frames. dout_valid and frame_err are never high in the same cycle.
- Unused lanes are impossible: a frame always fills exactly 8 slots. Slot wrap 7->0 happens only through completion.
- Gap counter width: ceil(log2(TIMEOUT+1)) bits; saturates and cannot wrap.

Optional Feature:
- Macro: DEMUX8_PARITY_CHECK_EN.
- Defined:
  - Frame is 9 slots: slots 0..7 are data, slot 8 is even parity over the data bits.
  - slot widens internally to 4 bits; the port stays 3 bits and reads 0 while the parity slot is pending.
  - On the parity bit: if XOR of the 9 bits is 0, update dout and pulse dout_valid. Otherwise pulse frame_err and leave dout unchanged.
  - Latency: one cycle after the parity bit is sampled.
  - Timeout and premature sof rules apply unchanged, including during the parity slot.
- Undefined: 8-slot frames exactly as in Behaviour; no parity logic present.

Test Plan:
- Reset, then send sof+bits 1,0,1,1,0,0,1,0 (slot0 first) on consecutive cycles -> dout=8'h4D, dout_valid high exactly one cycle after the 8th bit, slot returns to 0, busy drops.
- Two frames back-to-back, 8'hFF then 8'h00 with no gap -> two dout_valid pulses 8 cycles apart; dout=8'hFF then 8'h00; no frame_err.
- Frame 8'hA5 with din_valid deasserted for TIMEOUT-1 cycles after slot 3 -> completes normally, dout=8'hA5. Repeat with a TIMEOUT-cycle gap -> frame_err pulse, IDLE, dout keeps 8'hA5.
- sof reasserted at slot 5 of a frame, followed by a full 8'h3C frame -> one frame_err pulse at the restart, then dout=8'h3C with a single dout_valid.
- rst asserted at slot 4 of a frame -> all outputs return to reset values next cycle with no frame_err. din_valid bits without sof afterwards -> ignored, busy stays 0.
- With DEMUX8_PARITY_CHECK_EN: 8'h4D + parity 0 -> dout_valid, dout=8'h4D. 8'h4D + parity 1 -> frame_err, dout unchanged.
